// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined RV32I/RV64I immediate generator with a 2-entry skid buffer
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [3:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_extend_pipe: XLEN must be 32 or 64");
    end
  endgenerate
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t r_state, w_next;
  logic w_s, w_accept, w_pop, w_illegal, w_load_main, w_load_skid, w_unused;
  logic [XLEN-1:0] w_imm, r_imm, r_skid_imm;
  logic [TAG_W-1:0] r_tag, r_skid_tag;
  logic r_ill, r_skid_ill;
  assign w_s       = in_instr[31];
  assign w_illegal = in_fmt > 4'd8;
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // The opcode field never contributes to any immediate.
  assign w_unused  = &{1'b0, in_instr[6:0]};
  // Combinational immediate extraction for the incoming instruction
  always_comb begin
    w_imm = '0;
    case (in_fmt)
      4'd0: w_imm = {{(XLEN-12){w_s}}, in_instr[31:20]};
      4'd1: w_imm = {{(XLEN-12){1'b0}}, in_instr[31:20]};
      4'd2: w_imm = {{(XLEN-12){w_s}}, in_instr[31:25], in_instr[11:7]};
      4'd3: w_imm = {{(XLEN-12){w_s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      4'd4: w_imm = {{(XLEN-13){1'b0}}, w_s, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      4'd5: w_imm = {{(XLEN-31){w_s}}, in_instr[30:12], 12'b0};
      4'd6: w_imm = {{(XLEN-20){w_s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      4'd7: w_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
      4'd8: w_imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, in_instr[25:20]}
                                 : {{(XLEN-5){1'b0}}, in_instr[24:20]};
      default: w_imm = '0;
    endcase
  end
  // Main register takes new data when it is (or is becoming) the head; skid takes overflow
  assign w_load_main = (r_state == EMPTY && w_accept) || (r_state == ONE && w_accept && w_pop)
                    || (r_state == TWO && w_pop);
  assign w_load_skid = r_state == ONE && w_accept && !w_pop;
  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else r_state <= w_next;
  end
  // Next-state logic; flush empties the buffer regardless of handshakes
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_next = ONE;
      ONE:     if (w_accept && !w_pop) w_next = TWO;
               else if (!w_accept && w_pop) w_next = EMPTY;
      TWO:     if (w_pop) w_next = ONE;
      default: w_next = EMPTY;
    endcase
    if (flush) w_next = EMPTY;
  end
  // Handshake outputs decode the registered state only
  always_comb begin
    in_ready  = r_state != TWO;
    out_valid = r_state != EMPTY;
  end
  // Entry storage: main feeds the outputs, skid holds the second entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imm      <= '0;
      r_tag      <= '0;
      r_ill      <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else if (!flush) begin
      if (w_load_main) begin
        r_imm <= (r_state == TWO) ? r_skid_imm : w_imm;
        r_tag <= (r_state == TWO) ? r_skid_tag : in_tag;
        r_ill <= (r_state == TWO) ? r_skid_ill : w_illegal;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_imm;
        r_skid_tag <= in_tag;
        r_skid_ill <= w_illegal;
      end
    end
  end
  assign out_imm     = r_imm;
  assign out_tag     = r_tag;
  assign out_illegal = r_ill;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: table vectors plus scoreboard for XLEN=32 and XLEN=64 instances
module tb_imm_extend_pipe;
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  fmt;
    logic [63:0] e64;
    logic [31:0] e32;
    logic        ill;
  } vec_t;
  typedef struct {
    logic [63:0] e64;
    logic [31:0] e32;
    logic [31:0] tag;
    logic        ill;
  } exp_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_instr = '0, in_tag = '0;
  logic [3:0]  in_fmt = '0;
  logic rdy32, rdy64, v32, v64, ill32, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  vec_t vec[11];
  exp_t q[$];
  exp_t cur;
  int n_checks = 0, n_errors = 0, pops = 0, max_q = 0;
  imm_extend_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(v32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32));
  imm_extend_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(v64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Scoreboard: occupancy model, pop-and-compare, push on accept
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid64", 64'(v64), 64'(q.size() > 0));
      chk("out_valid32", 64'(v32), 64'(q.size() > 0));
      chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
      chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
      if (q.size() > max_q) max_q = q.size();
    end
    if (reset || flush) q.delete();
    else begin
      if (v64 && out_ready) begin
        pops++;
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got tag %h expected no output", tag64);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("imm64", imm64, e.e64);
          chk("imm32", 64'(imm32), 64'(e.e32));
          chk("tag64", 64'(tag64), 64'(e.tag));
          chk("tag32", 64'(tag32), 64'(e.tag));
          chk("ill64", 64'(ill64), 64'(e.ill));
          chk("ill32", 64'(ill32), 64'(e.ill));
        end
      end
      if (in_valid && rdy64) q.push_back(cur);
    end
  end
  task automatic send(input int v, input logic [31:0] tag);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    in_valid = 1;
    in_instr = vec[v].instr;
    in_fmt   = vec[v].fmt;
    in_tag   = tag;
    cur.e64 = vec[v].e64;
    cur.e32 = vec[v].e32;
    cur.tag = tag;
    cur.ill = vec[v].ill;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rdy64;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 0;
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask
  task automatic flush_cycle(input logic [31:0] tag);
    in_valid = 1;
    in_instr = 32'hFFFFFFFF;
    in_fmt   = 4'd0;
    in_tag   = tag;
    cur.e64 = '1;
    cur.e32 = '1;
    cur.tag = tag;
    cur.ill = 0;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", 64'(v64), 64'd0);
    chk("flush_in_ready", 64'(rdy64), 64'd1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int p0;
    vec[0]  = '{32'hFFF00093, 4'd0, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vec[1]  = '{32'hFFF00093, 4'd1, 64'h0000000000000FFF, 32'h00000FFF, 1'b0};
    vec[2]  = '{32'h800000EF, 4'd6, 64'hFFFFFFFFFFF00000, 32'hFFF00000, 1'b0};
    vec[3]  = '{32'hFE000FE3, 4'd3, 64'hFFFFFFFFFFFFFFFE, 32'hFFFFFFFE, 1'b0};
    vec[4]  = '{32'hFE000FE3, 4'd4, 64'h0000000000001FFE, 32'h00001FFE, 1'b0};
    vec[5]  = '{32'h800002B7, 4'd5, 64'hFFFFFFFF80000000, 32'h80000000, 1'b0};
    vec[6]  = '{32'h03F01013, 4'd8, 64'h000000000000003F, 32'h0000001F, 1'b0};
    vec[7]  = '{32'h000FD073, 4'd7, 64'h000000000000001F, 32'h0000001F, 1'b0};
    vec[8]  = '{32'h80000F80, 4'd2, 64'hFFFFFFFFFFFFF81F, 32'hFFFFF81F, 1'b0};
    vec[9]  = '{32'hFFFFFFFF, 4'd12, 64'h0, 32'h0, 1'b1};
    vec[10] = '{32'hFFFFFFFF, 4'd15, 64'h0, 32'h0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_tag64", 64'(tag64), 64'd0);
    chk("rst_ill64", 64'(ill64), 64'd0);
    chk("rst_imm32", 64'(imm32), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) send(i, 32'h100 + i);
    drain();
    p0 = pops;
    out_ready = 0;
    fork
      for (int t = 1; t <= 5; t++) send(t, t);
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(rdy64), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain();
    chk("bp_pop_count", 64'(pops - p0), 64'd5);
    p0 = pops;
    max_q = 0;
    for (int i = 0; i < 11; i++) send(i, 32'h200 + i);
    drain();
    chk("stream_max_occ", 64'(max_q), 64'd1);
    chk("stream_pop_count", 64'(pops - p0), 64'd11);
    out_ready = 0;
    send(0, 32'h31);
    send(1, 32'h32);
    flush_cycle(32'hBAD0);
    send(2, 32'h33);
    flush_cycle(32'hBAD1);
    out_ready = 1;
    send(5, 32'h77);
    drain();
    out_ready = 0;
    send(3, 32'h41);
    send(4, 32'h42);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst2_valid", 64'(v64), 64'd0);
    chk("rst2_in_ready", 64'(rdy64), 64'd1);
    chk("rst2_imm64", imm64, 64'd0);
    chk("rst2_imm32", 64'(imm32), 64'd0);
    chk("rst2_tag", 64'(tag64), 64'd0);
    chk("rst2_ill", 64'(ill64), 64'd0);
    out_ready = 1;
    @(posedge clk);
    #1;
    send(9, 32'hCAFE);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate generator for the pipelined RV32I/RV64I core. It decodes the immediate of one 32-bit instruction word per cycle to XLEN bits and carries a sideband tag (PC or ROB index) alongside. It sits between decode and the operand-select stage, with a valid/ready handshake and a 2-entry skid buffer so back-pressure never drops or duplicates an instruction. It also adds CSR-zimm and shift-amount formats and an illegal-format flag.

## Interface
Parameters:
- XLEN, 32, output width; legal values 32 or 64 (any other value is a synthesis error)
- TAG_W, 32, width of the sideband tag passed through unchanged

Ports:
- clk  in  1  single clock; everything is on the rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous; drops all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept this cycle
- in_instr  in  32  raw instruction word
- in_fmt  in  4  immediate format: 0 I, 1 Iu, 2 S, 3 B, 4 Bu, 5 U, 6 J, 7 Z, 8 SH; 9–15 illegal
- in_tag  in  TAG_W  sideband
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the same entry
- out_illegal  out  1  in_fmt was 9–15; out_imm is 0

## Operation
- Format extraction (s = in_instr[31]; signed formats sign-extend to XLEN):
  - I: s-ext [31:20]
  - Iu: zero-ext [31:20]
  - S: s-ext {[31:25],[11:7]}
  - B: s-ext {[31],[7],[30:25],[11:8],0}
  - Bu: zero-ext of the same 13 bits
  - U: {[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64
  - J: s-ext {[31],[19:12],[20],[30:21],0}
  - Z: zero-ext [19:15]
  - SH: zero-ext [25:20] when XLEN=64, [24:20] when XLEN=32
  - 9–15: imm = 0, illegal = 1
- Extraction is combinational on the input side. The registered result (imm, tag, illegal) is what gets stored.
- Storage is a 2-entry skid buffer: a main register feeding the outputs and a skid register.
- State machine:
  - EMPTY: out_valid=0, in_ready=1. On accept, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept without pop: go to TWO (new entry goes to skid).
    - Pop without accept: go to EMPTY.
    - Accept and pop together: stay in ONE; main register loads the new entry.
  - TWO: out_valid=1, in_ready=0. On pop, main loads from skid and the state goes to ONE. No accept is possible.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Order is strictly FIFO. Tags never separate from their immediates.
- flush: state goes to EMPTY on the next edge. Any accept in the flush cycle is discarded. Flush has priority over accept and pop.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is on the outputs after edge N, when the buffer is empty or the entry is popped through.
- Sustained throughput is 1 per cycle with out_ready held high.
- in_ready is a pure register decode of the state (no combinational path from out_ready). It drops the cycle after the buffer fills.
- out_* are registered and stable while out_valid=1 and out_ready=0.
- Reset values: state EMPTY, out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0.
- Reset asserted mid-stream discards both entries. Reset has priority over flush.
- When out_valid=0, out_imm/out_tag hold their last value. Verification must not check them.

## Test plan
- Formats, XLEN=32, out_ready=1: in_instr=0xFFF00093 fmt I -> 0xFFFFFFFF. fmt Iu -> 0x00000FFF. 0x800000EF fmt J -> 0xFFF00000. 0xFE000FE3 fmt B -> 0xFFFFFFFE. fmt Bu -> 0x00001FFE.
- XLEN=64: 0x800002B7 fmt U -> 0xFFFFFFFF80000000. 0x03F01013 fmt SH -> 0x3F. 0x000FD073 fmt Z -> 0x1F.
- Back-pressure: stream tags 1..5 with out_ready low for 3 cycles after the first accept. in_ready must fall after 2 entries are held. Output order must be 1,2,3,4,5 with no loss or duplicates.
- Simultaneous accept and pop in ONE every cycle for 10 cycles: one output per cycle, state never reaches TWO.
- Flush in TWO with in_valid high: the next cycle shows out_valid=0 and in_ready=1, and the flushed-cycle input never appears.
- fmt=12: out_illegal=1, out_imm=0, tag preserved. Reset in TWO gives the reset values on the next cycle.
